// File: rtl/prio_arb_mux.sv
// prio_arb_mux: arbitrates NCH valid/ready input channels into a single-entry
// registered output stage with one cycle of latency and full throughput.
// Compile-time option: define PRIO_ARB_MUX_RR_EN for round-robin arbitration
// (adds a last_grant register); leave it undefined for fixed priority where
// the lowest-index requester always wins.
module prio_arb_mux #(
   parameter  int WIDTH = 8,
   parameter  int NCH   = 4,
   localparam int SELW  = (NCH > 1) ? $clog2(NCH) : 1
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [NCH*WIDTH-1:0] in_data,
   input  logic [NCH-1:0]       in_valid,
   output logic [NCH-1:0]       in_ready,
   output logic [WIDTH-1:0]     out_data,
   output logic [SELW-1:0]      out_sel,
   output logic                 out_valid,
   input  logic                 out_ready
);

   logic             load;
   logic             any_req;
   logic [SELW-1:0]  grant_idx;
   logic             xfer;

   logic             out_valid_q, out_valid_d;
   logic [WIDTH-1:0] out_data_q,  out_data_d;
   logic [SELW-1:0]  out_sel_q,   out_sel_d;

`ifdef PRIO_ARB_MUX_RR_EN
   logic [SELW-1:0]  last_grant_q, last_grant_d;

   // Round-robin pick: first requester found searching upward from last_grant+1, wrapping at NCH
   always_comb begin
      int idx;
      idx       = 0;
      any_req   = 1'b0;
      grant_idx = '0;
      for (int k = 1; k <= NCH; k++) begin
         idx = (int'(last_grant_q) + k) % NCH;
         if (!any_req && in_valid[idx]) begin
            any_req   = 1'b1;
            grant_idx = SELW'(idx);
         end
      end
   end

   // The rotation pointer only advances when a channel actually hands over data
   always_comb begin
      last_grant_d = last_grant_q;
      if (xfer) begin
         last_grant_d = grant_idx;
      end
   end

   // Pointer resets to the top channel so the first search begins at channel 0
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         last_grant_q <= SELW'(NCH - 1);
      end else begin
         last_grant_q <= last_grant_d;
      end
   end
`else
   // Fixed priority pick: the lowest-index requester wins
   always_comb begin
      any_req   = |in_valid;
      grant_idx = '0;
      for (int i = NCH - 1; i >= 0; i--) begin
         if (in_valid[i]) begin
            grant_idx = SELW'(i);
         end
      end
   end
`endif

   // Grant is issued only when the stage can take data, and never while reset is held
   always_comb begin
      load     = !out_valid_q || out_ready;
      in_ready = '0;
      if (rst_n && load && any_req) begin
         in_ready = NCH'(1) << grant_idx;
      end
      xfer = |(in_ready & in_valid);
   end

   // Refill the stage on a transfer, empty it on a drain without refill, otherwise hold
   always_comb begin
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      out_sel_d   = out_sel_q;
      if (load) begin
         out_valid_d = xfer;
         if (xfer) begin
            out_data_d = in_data[int'(grant_idx)*WIDTH +: WIDTH];
            out_sel_d  = grant_idx;
         end
      end
   end

   // Output stage register; reset discards any held word immediately
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_sel_q   <= '0;
      end else begin
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_sel_q   <= out_sel_d;
      end
   end

   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign out_sel   = out_sel_q;

endmodule

// File: tb/tb_prio_arb_mux.sv
// tb_prio_arb_mux: directed bench for prio_arb_mux with a reference model.
// Build with PRIO_ARB_MUX_RR_EN defined to check round-robin mode instead of
// fixed priority.
module tb_prio_arb_mux;

   localparam int WIDTH = 8;
   localparam int NCH   = 4;

   logic        clk       = 1'b0;
   logic        rst_n     = 1'b0;
   logic [31:0] in_data   = 32'h4433_2211;
   logic [3:0]  in_valid  = 4'b1111;
   logic        out_ready = 1'b1;
   logic [3:0]  in_ready;
   logic [7:0]  out_data;
   logic [1:0]  out_sel;
   logic        out_valid;

   int checks   = 0;
   int failures = 0;

   // Reference model state: what the output register should hold
   bit         m_valid = 1'b0;
   logic [7:0] m_data  = 8'h00;
   int         m_sel   = 0;
`ifdef PRIO_ARB_MUX_RR_EN
   int         m_last  = NCH - 1;
`endif

   prio_arb_mux #(.WIDTH(WIDTH), .NCH(NCH)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .in_data  (in_data),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .out_data (out_data),
      .out_sel  (out_sel),
      .out_valid(out_valid),
      .out_ready(out_ready)
   );

   // Free-running clock, 10 time-unit period
   always #5 clk = ~clk;

   // Which channel should win given the request vector; -1 when nobody asks
   function automatic int winner(logic [3:0] v);
`ifdef PRIO_ARB_MUX_RR_EN
      for (int k = 1; k <= NCH; k++) begin
         if (v[(m_last + k) % NCH]) return (m_last + k) % NCH;
      end
`else
      for (int i = 0; i < NCH; i++) begin
         if (v[i]) return i;
      end
`endif
      return -1;
   endfunction

   // Expected handshake vector from the model and the current inputs
   function automatic logic [3:0] exp_ready();
      int w;
      if (!rst_n) return 4'b0000;
      if (m_valid && !out_ready) return 4'b0000;
      w = winner(in_valid);
      if (w < 0) return 4'b0000;
      return 4'(1 << w);
   endfunction

   task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, actual, expected, $time);
      end
   endtask

   task automatic applyStimulus(input logic [3:0] v, input logic [31:0] d, input logic rdy);
      in_valid  = v;
      in_data   = d;
      out_ready = rdy;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Model update: a loadable stage takes the winning channel's word, or empties
   always @(posedge clk or negedge rst_n) begin
      int w;
      if (!rst_n) begin
         m_valid = 1'b0;
         m_data  = 8'h00;
         m_sel   = 0;
`ifdef PRIO_ARB_MUX_RR_EN
         m_last  = NCH - 1;
`endif
      end else if (!m_valid || out_ready) begin
         w = winner(in_valid);
         if (w >= 0) begin
            m_valid = 1'b1;
            m_data  = in_data[w*WIDTH +: WIDTH];
            m_sel   = w;
`ifdef PRIO_ARB_MUX_RR_EN
            m_last  = w;
`endif
         end else begin
            m_valid = 1'b0;
         end
      end
   end

   // Every cycle, compare the DUT against the model mid-period
   always @(negedge clk) begin
      checkOutput("cmp_out_valid", 64'(out_valid), 64'(m_valid));
      checkOutput("cmp_in_ready", 64'(in_ready), 64'(exp_ready()));
      if (m_valid || !rst_n) begin
         checkOutput("cmp_out_data", 64'(out_data), 64'(m_data));
         checkOutput("cmp_out_sel", 64'(out_sel), 64'(m_sel));
      end
   end

   // Directed scenarios with literal expectations
   initial begin
      logic [1:0] rr_seq [10];
      logic [1:0] fp_seq [10];
      rr_seq = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd3, 2'd1, 2'd3, 2'd1};
      fp_seq = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd1, 2'd1, 2'd1, 2'd1};

      // Reset held for three edges with every channel requesting
      repeat (3) @(posedge clk);
      #1;
      checkOutput("rst_out_valid", 64'(out_valid), 64'd0);
      checkOutput("rst_out_data", 64'(out_data), 64'h00);
      checkOutput("rst_out_sel", 64'(out_sel), 64'd0);
      checkOutput("rst_in_ready", 64'(in_ready), 64'd0);
      rst_n = 1'b1;

      // Lone requester on channel 2, twice back to back
      applyStimulus(4'b0100, 32'h00A5_0000, 1'b1);
      #1;
      checkOutput("single_in_ready", 64'(in_ready), 64'b0100);
      step();
      checkOutput("single_out_data", 64'(out_data), 64'hA5);
      checkOutput("single_out_sel", 64'(out_sel), 64'd2);
      checkOutput("single_out_valid", 64'(out_valid), 64'd1);
      applyStimulus(4'b0100, 32'h005A_0000, 1'b1);
      step();
      checkOutput("b2b_out_data", 64'(out_data), 64'h5A);
      checkOutput("b2b_out_sel", 64'(out_sel), 64'd2);

      // Backpressure: 0x3C from channel 0 must hold for four stalled cycles
      applyStimulus(4'b0001, 32'h0000_003C, 1'b1);
      step();
      checkOutput("bp_load_data", 64'(out_data), 64'h3C);
      applyStimulus(4'b1111, 32'h4433_2211, 1'b0);
      for (int c = 0; c < 4; c++) begin
         #1;
         checkOutput("bp_in_ready", 64'(in_ready), 64'd0);
         step();
         checkOutput("bp_hold_data", 64'(out_data), 64'h3C);
         checkOutput("bp_hold_valid", 64'(out_valid), 64'd1);
      end
      out_ready = 1'b1;
      #1;
`ifdef PRIO_ARB_MUX_RR_EN
      checkOutput("bp_release_ready", 64'(in_ready), 64'b0010);
      step();
      checkOutput("bp_refill_data", 64'(out_data), 64'h22);
`else
      checkOutput("bp_release_ready", 64'(in_ready), 64'b0001);
      step();
      checkOutput("bp_refill_data", 64'(out_data), 64'h11);
`endif

      // Arbitration order from a fresh reset: six grants with all four requesting,
      // then channels 1 and 3 only; after the sixth grant (channel 1) the
      // round-robin search resumes at channel 2, so channel 3 comes first
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      applyStimulus(4'b1111, 32'h4433_2211, 1'b1);
      for (int c = 0; c < 10; c++) begin
         if (c == 6) applyStimulus(4'b1010, 32'h4433_2211, 1'b1);
         step();
`ifdef PRIO_ARB_MUX_RR_EN
         checkOutput("arb_seq_sel", 64'(out_sel), 64'(rr_seq[c]));
`else
         checkOutput("arb_seq_sel", 64'(out_sel), 64'(fp_seq[c]));
`endif
      end
`ifndef PRIO_ARB_MUX_RR_EN
      // Fixed priority keeps channel 0 for a long all-request stretch
      applyStimulus(4'b1111, 32'h4433_2211, 1'b1);
      for (int c = 0; c < 8; c++) begin
         step();
         checkOutput("fixed_sel0", 64'(out_sel), 64'd0);
      end
`endif

      // Drain with no requests empties the stage
      applyStimulus(4'b0000, 32'h0, 1'b1);
      step();
      checkOutput("drain_out_valid", 64'(out_valid), 64'd0);

      // Reset between edges while the stage is stalled full
      applyStimulus(4'b0100, 32'h00A5_0000, 1'b1);
      step();
      applyStimulus(4'b0000, 32'h0, 1'b0);
      step();
      checkOutput("midrst_before_valid", 64'(out_valid), 64'd1);
      #2;
      rst_n = 1'b0;
      #1;
      checkOutput("midrst_out_valid", 64'(out_valid), 64'd0);
      checkOutput("midrst_out_data", 64'(out_data), 64'h00);
      checkOutput("midrst_in_ready", 64'(in_ready), 64'd0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      applyStimulus(4'b1111, 32'h4433_2211, 1'b1);
      step();
      checkOutput("post_rst_sel", 64'(out_sel), 64'd0);
      checkOutput("post_rst_data", 64'(out_data), 64'h11);
      step();
`ifdef PRIO_ARB_MUX_RR_EN
      checkOutput("post_rst_next_sel", 64'(out_sel), 64'd1);
`else
      checkOutput("post_rst_next_sel", 64'(out_sel), 64'd0);
`endif

      applyStimulus(4'b0000, 32'h0, 1'b1);
      repeat (2) step();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
